// File: rtl/fft_bin_collector_if.sv
// Bus interface for fft_bin_collector.
// Groups the serial bin input, the frame handshake and the random-access read port.
//   slave  : the collector (consumes bins, serves frames)
//   master : the source/consumer side (drives bins, frame_ready, rd_addr)
interface fft_bin_collector_if #(
   parameter int unsigned DW = 16,
   parameter int unsigned CW = 8
) ();
   logic          in_valid;
   logic [DW-1:0] in_re;
   logic [DW-1:0] in_im;
   logic [2:0]    in_index;
   logic          frame_valid;
   logic          frame_ready;
   logic [2:0]    rd_addr;
   logic [DW-1:0] rd_re;
   logic [DW-1:0] rd_im;
   logic [DW:0]   rd_mag;
   logic [2:0]    peak_index;
   logic [DW:0]   peak_mag;
   logic          seq_err;
   logic [CW-1:0] err_cnt;
   logic [CW-1:0] drop_cnt;

   modport slave (
      input  in_valid, in_re, in_im, in_index, frame_ready, rd_addr,
      output frame_valid, rd_re, rd_im, rd_mag, peak_index, peak_mag,
             seq_err, err_cnt, drop_cnt
   );

   modport master (
      output in_valid, in_re, in_im, in_index, frame_ready, rd_addr,
      input  frame_valid, rd_re, rd_im, rd_mag, peak_index, peak_mag,
             seq_err, err_cnt, drop_cnt
   );
endinterface

// File: rtl/fft_bin_collector.sv
// Reassembles a serial FFT bin stream (index 0..7) into 8-bin frames held in a
// double-buffered frame store, tracks |re|+|im| and the peak bin per frame, and
// hands complete frames to a consumer via frame_valid/frame_ready plus a
// 1-cycle-latency random-access read port.
// Ports:
//   clk  - clock
//   rst  - synchronous active-low reset
//   bus  - fft_bin_collector_if.slave (bin input, frame handshake, read port,
//          peak, seq_err pulse, saturating err/drop counters)
module fft_bin_collector #(
   parameter int unsigned DW = 16,
   parameter int unsigned CW = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   fft_bin_collector_if.slave   bus
);

   localparam int unsigned MW = DW + 1;

   typedef enum logic {
      ST_SYNC = 1'b0,
      ST_FILL = 1'b1
   } state_t;

   // Frame store: two banks of 8 bins plus per-bank peak
   logic [DW-1:0] r_re     [2][8];
   logic [DW-1:0] r_im     [2][8];
   logic [MW-1:0] r_mag    [2][8];
   logic [2:0]    r_pk_idx [2];
   logic [MW-1:0] r_pk_mag [2];
   logic [1:0]    r_full;
   logic          r_wb;
   logic          r_rb;

   state_t        r_state;
   logic [2:0]    r_expect;

   logic [DW-1:0] r_rd_re;
   logic [DW-1:0] r_rd_im;
   logic [MW-1:0] r_rd_mag;
   logic          r_seq_err;
   logic [CW-1:0] r_err_cnt;
   logic [CW-1:0] r_drop_cnt;

   // |re|+|im|: sign-extend one bit first so |-2^(DW-1)| is exact
   logic [MW-1:0] w_re_x, w_im_x, w_abs_re, w_abs_im, w_mag;
   assign w_re_x   = {bus.in_re[DW-1], bus.in_re};
   assign w_im_x   = {bus.in_im[DW-1], bus.in_im};
   assign w_abs_re = w_re_x[MW-1] ? MW'(-w_re_x) : w_re_x;
   assign w_abs_im = w_im_x[MW-1] ? MW'(-w_im_x) : w_im_x;
   assign w_mag    = w_abs_re + w_abs_im;

   // Index 0 opens a frame from SYNC, or restarts one after an out-of-order bin
   logic w_mismatch, w_begin, w_store;
   assign w_mismatch = (r_state == ST_FILL) && (bus.in_index != r_expect);
   assign w_begin    = (bus.in_index == 3'd0) && ((r_state == ST_SYNC) || w_mismatch);
   assign w_store    = (r_state == ST_FILL) && !w_mismatch;

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 8; i++) begin
               r_re[b][i]  <= '0;
               r_im[b][i]  <= '0;
               r_mag[b][i] <= '0;
            end
            r_pk_idx[b] <= '0;
            r_pk_mag[b] <= '0;
         end
         r_full     <= '0;
         r_wb       <= 1'b0;
         r_rb       <= 1'b0;
         r_state    <= ST_SYNC;
         r_expect   <= '0;
         r_rd_re    <= '0;
         r_rd_im    <= '0;
         r_rd_mag   <= '0;
         r_seq_err  <= 1'b0;
         r_err_cnt  <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_seq_err <= 1'b0;

         // Read port samples the bank visible before this edge
         if (r_full[r_rb]) begin
            r_rd_re  <= r_re[r_rb][bus.rd_addr];
            r_rd_im  <= r_im[r_rb][bus.rd_addr];
            r_rd_mag <= r_mag[r_rb][bus.rd_addr];
         end else begin
            r_rd_re  <= '0;
            r_rd_im  <= '0;
            r_rd_mag <= '0;
         end

         // Consumer release; never the bank being written, so no conflict with completion
         if (r_full[r_rb] && bus.frame_ready) begin
            r_full[r_rb] <= 1'b0;
            r_rb         <= ~r_rb;
         end

         if (bus.in_valid) begin
            if (w_mismatch) begin
               r_seq_err <= 1'b1;
               if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CW'(1);
               r_state <= ST_SYNC;
            end

            if (w_begin) begin
               if (!r_full[r_wb]) begin
                  r_re[r_wb][0]  <= bus.in_re;
                  r_im[r_wb][0]  <= bus.in_im;
                  r_mag[r_wb][0] <= w_mag;
                  r_pk_idx[r_wb] <= 3'd0;
                  r_pk_mag[r_wb] <= w_mag;
                  r_expect       <= 3'd1;
                  r_state        <= ST_FILL;
               end else if (r_drop_cnt != '1) begin
                  r_drop_cnt <= r_drop_cnt + CW'(1);
               end
            end else if (w_store) begin
               r_re[r_wb][bus.in_index]  <= bus.in_re;
               r_im[r_wb][bus.in_index]  <= bus.in_im;
               r_mag[r_wb][bus.in_index] <= w_mag;
               // Strictly greater: ties keep the lower index
               if (w_mag > r_pk_mag[r_wb]) begin
                  r_pk_idx[r_wb] <= bus.in_index;
                  r_pk_mag[r_wb] <= w_mag;
               end
               if (r_expect == 3'd7) begin
                  r_full[r_wb] <= 1'b1;
                  r_wb         <= ~r_wb;
                  r_state      <= ST_SYNC;
               end else begin
                  r_expect <= r_expect + 3'd1;
               end
            end
         end
      end
   end

   assign bus.frame_valid = r_full[r_rb];
   assign bus.peak_index  = r_full[r_rb] ? r_pk_idx[r_rb] : 3'd0;
   assign bus.peak_mag    = r_full[r_rb] ? r_pk_mag[r_rb] : '0;
   assign bus.rd_re       = r_rd_re;
   assign bus.rd_im       = r_rd_im;
   assign bus.rd_mag      = r_rd_mag;
   assign bus.seq_err     = r_seq_err;
   assign bus.err_cnt     = r_err_cnt;
   assign bus.drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_fft_bin_collector.sv
// Self-checking bench for fft_bin_collector: directed scenarios with literal
// expectations plus a randomized stream, all checked every cycle against a
// frame-queue model of the collector.
module tb_fft_bin_collector;
   localparam int unsigned DW = 16;
   localparam int unsigned CW = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fft_bin_collector_if #(.DW(DW), .CW(CW)) bus ();
   fft_bin_collector #(.DW(DW), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic [7:0][DW-1:0] re;
      logic [7:0][DW-1:0] im;
   } frame_t;

   // Model: queue of completed frames (at most two), a frame under assembly
   frame_t        m_q[$];
   frame_t        m_cur;
   bit            m_sync = 1'b1;
   int            m_exp  = 0;
   int            m_err  = 0;
   int            m_drop = 0;
   logic [DW-1:0] e_rd_re  = '0;
   logic [DW-1:0] e_rd_im  = '0;
   logic [DW:0]   e_rd_mag = '0;
   logic          e_seq    = 1'b0;
   bit            chk_en   = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [DW:0] magf(input logic [DW-1:0] re, input logic [DW-1:0] im);
      int a, b;
      a = $signed(re);
      b = $signed(im);
      if (a < 0) a = -a;
      if (b < 0) b = -b;
      return (DW+1)'(a + b);
   endfunction

   function automatic int peak_of(input frame_t f);
      int best;
      best = 0;
      for (int k = 1; k < 8; k++)
         if (magf(f.re[k], f.im[k]) > magf(f.re[best], f.im[best])) best = k;
      return best;
   endfunction

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model update on the same edge the DUT samples its inputs
   always @(posedge clk) begin : model
      bit rel;
      int idx;
      if (!rst) begin
         m_q.delete();
         m_sync   = 1'b1;
         m_exp    = 0;
         m_err    = 0;
         m_drop   = 0;
         e_rd_re  = '0;
         e_rd_im  = '0;
         e_rd_mag = '0;
         e_seq    = 1'b0;
      end else begin
         rel = (m_q.size() > 0) && bus.frame_ready;
         if (m_q.size() > 0) begin
            e_rd_re  = m_q[0].re[bus.rd_addr];
            e_rd_im  = m_q[0].im[bus.rd_addr];
            e_rd_mag = magf(e_rd_re, e_rd_im);
         end else begin
            e_rd_re  = '0;
            e_rd_im  = '0;
            e_rd_mag = '0;
         end
         e_seq = 1'b0;
         if (bus.in_valid) begin
            idx = int'(bus.in_index);
            if (!m_sync && idx != m_exp) begin
               e_seq  = 1'b1;
               m_err++;
               m_sync = 1'b1;
            end
            if (m_sync) begin
               if (idx == 0) begin
                  if (m_q.size() == 2) m_drop++;
                  else begin
                     m_cur       = '0;
                     m_cur.re[0] = bus.in_re;
                     m_cur.im[0] = bus.in_im;
                     m_exp       = 1;
                     m_sync      = 1'b0;
                  end
               end
            end else begin
               m_cur.re[idx] = bus.in_re;
               m_cur.im[idx] = bus.in_im;
               if (idx == 7) begin
                  m_q.push_back(m_cur);
                  m_sync = 1'b1;
               end else m_exp++;
            end
         end
         if (rel) void'(m_q.pop_front());
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin : compare
      bit          fv;
      int          pi;
      logic [DW:0] pm;
      if (chk_en) begin
         fv = m_q.size() > 0;
         pi = 0;
         pm = '0;
         if (fv) begin
            pi = peak_of(m_q[0]);
            pm = magf(m_q[0].re[pi], m_q[0].im[pi]);
         end
         chk("frame_valid", bus.frame_valid, fv);
         chk("peak_index", bus.peak_index, pi);
         chk("peak_mag", bus.peak_mag, pm);
         chk("rd_re", $signed(bus.rd_re), $signed(e_rd_re));
         chk("rd_im", $signed(bus.rd_im), $signed(e_rd_im));
         chk("rd_mag", bus.rd_mag, e_rd_mag);
         chk("seq_err", bus.seq_err, e_seq);
         chk("err_cnt", bus.err_cnt, sat(m_err));
         chk("drop_cnt", bus.drop_cnt, sat(m_drop));
      end
   end

   task automatic drive(input bit v, input int re, input int im, input int idx);
      bus.in_valid = v;
      bus.in_re    = DW'(re);
      bus.in_im    = DW'(im);
      bus.in_index = 3'(idx);
      @(negedge clk);
   endtask

   task automatic send_frame(input int re[8], input int im[8]);
      for (int k = 0; k < 8; k++) drive(1'b1, re[k], im[k], k);
   endtask

   task automatic release_frame();
      bus.frame_ready = 1'b1;
      drive(1'b0, 0, 0, 0);
      bus.frame_ready = 1'b0;
   endtask

   function automatic int rval();
      case ($urandom_range(0, 7))
         0:       return -32768;
         1:       return 32767;
         default: return int'($urandom_range(0, 65535)) - 32768;
      endcase
   endfunction

   int fr_re[3][8];
   int fr_im[3][8];
   int a_re[8];
   int a_im[8];

   initial begin
      bus.in_valid    = 1'b0;
      bus.in_re       = '0;
      bus.in_im       = '0;
      bus.in_index    = '0;
      bus.frame_ready = 1'b0;
      bus.rd_addr     = '0;
      rst             = 1'b0;
      repeat (2) @(negedge clk);
      rst    = 1'b1;
      chk_en = 1'b1;
      chk("reset_frame_valid", bus.frame_valid, 0);
      chk("reset_err_cnt", bus.err_cnt, 0);

      // Clean frame: bin k = (100k, -50k)
      for (int k = 0; k < 8; k++) begin a_re[k] = 100 * k; a_im[k] = -50 * k; end
      bus.rd_addr = 3'd7;
      send_frame(a_re, a_im);
      chk("t2_frame_valid", bus.frame_valid, 1);
      chk("t2_peak_index", bus.peak_index, 7);
      chk("t2_peak_mag", bus.peak_mag, 1050);
      drive(1'b0, 0, 0, 0);
      chk("t2_rd_re", $signed(bus.rd_re), 700);
      chk("t2_rd_im", $signed(bus.rd_im), -350);
      chk("t2_rd_mag", bus.rd_mag, 1050);
      release_frame();

      // Most-negative components and peak tie-break
      for (int k = 0; k < 8; k++) begin a_re[k] = 0; a_im[k] = 0; end
      a_re[3] = -32768; a_im[3] = -32768;
      bus.rd_addr = 3'd3;
      send_frame(a_re, a_im);
      drive(1'b0, 0, 0, 0);
      chk("t3_rd_mag", bus.rd_mag, 65536);
      chk("t3_peak_index", bus.peak_index, 3);
      release_frame();
      for (int k = 0; k < 8; k++) begin a_re[k] = 1; a_im[k] = -1; end
      a_re[2] = 300; a_im[2] = -200;
      a_re[5] = -500; a_im[5] = 0;
      send_frame(a_re, a_im);
      chk("t3_tie_index", bus.peak_index, 2);
      chk("t3_tie_mag", bus.peak_mag, 500);
      release_frame();

      // Three frames with no consumer: third dropped
      for (int f = 0; f < 3; f++)
         for (int k = 0; k < 8; k++) begin fr_re[f][k] = rval(); fr_im[f][k] = rval(); end
      bus.rd_addr = 3'd4;
      for (int f = 0; f < 3; f++) send_frame(fr_re[f], fr_im[f]);
      chk("t4_drop_cnt", bus.drop_cnt, 1);
      release_frame();
      chk("t4_frame_valid", bus.frame_valid, 1);
      drive(1'b0, 0, 0, 0);
      chk("t4_rd_re_frame2", $signed(bus.rd_re), fr_re[1][4]);
      chk("t4_rd_im_frame2", $signed(bus.rd_im), fr_im[1][4]);
      release_frame();
      drive(1'b0, 0, 0, 0);
      chk("t4_empty", bus.frame_valid, 0);

      // Out-of-sequence index mid-frame
      drive(1'b1, 11, 12, 0);
      drive(1'b1, 13, 14, 1);
      drive(1'b1, 15, 16, 2);
      drive(1'b1, 17, 18, 4);
      chk("t5_seq_err", bus.seq_err, 1);
      chk("t5_err_cnt", bus.err_cnt, 1);
      for (int k = 0; k < 8; k++) begin a_re[k] = rval(); a_im[k] = rval(); end
      send_frame(a_re, a_im);
      chk("t5_frame_valid", bus.frame_valid, 1);
      release_frame();
      drive(1'b0, 0, 0, 0);
      chk("t5_single_frame", bus.frame_valid, 0);

      // Leading partial frame and in_valid gaps
      drive(1'b1, 5, 5, 5);
      drive(1'b1, 6, 6, 6);
      drive(1'b1, 7, 7, 7);
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 1000 + k, -k, k);
         if (k % 3 == 1) drive(1'b0, rval(), rval(), $urandom_range(0, 7));
      end
      chk("t6_frame_valid", bus.frame_valid, 1);
      chk("t6_err_cnt", bus.err_cnt, 1);
      release_frame();
      drive(1'b0, 0, 0, 0);
      chk("t6_single_frame", bus.frame_valid, 0);

      // Reset mid-fill with a stored frame present
      for (int k = 0; k < 8; k++) begin a_re[k] = rval(); a_im[k] = rval(); end
      send_frame(a_re, a_im);
      for (int k = 0; k < 4; k++) drive(1'b1, rval(), rval(), k);
      rst = 1'b0;
      drive(1'b0, 0, 0, 0);
      drive(1'b0, 0, 0, 0);
      rst = 1'b1;
      chk("t1_frame_valid", bus.frame_valid, 0);
      chk("t1_peak_mag", bus.peak_mag, 0);
      chk("t1_rd_mag", bus.rd_mag, 0);
      chk("t1_err_cnt", bus.err_cnt, 0);
      chk("t1_drop_cnt", bus.drop_cnt, 0);
      for (int k = 0; k < 8; k++) begin a_re[k] = 10 * k; a_im[k] = 0; end
      send_frame(a_re, a_im);
      chk("t1_after_frame_valid", bus.frame_valid, 1);
      chk("t1_after_peak", bus.peak_index, 7);
      release_frame();

      // Randomized stream: mostly in order, occasional jumps, gaps and releases
      begin
         int g;
         int idx;
         g = 0;
         for (int c = 0; c < 3000; c++) begin
            bus.frame_ready = ($urandom_range(0, 3) == 0);
            bus.rd_addr     = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) begin
               drive(1'b0, rval(), rval(), $urandom_range(0, 7));
            end else begin
               idx = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : g;
               drive(1'b1, rval(), rval(), idx);
               g = (idx + 1) % 8;
            end
         end
         bus.frame_ready = 1'b0;
      end
      drive(1'b0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
